uart_writer: RTL and testbench

Readback path of the UART NTT link: on a start pulse it streams a block of 32-bit words from the accelerator's memory out over the UART transmitter as bytes. It emits the same framing the host uses on the load path: a 2-word header (start address, word count) followed by the data words, each word sent least-significant byte first. It sits between the coefficient/result memory read port and the UART TX byte interface.

---
 rtl/uart_writer_if.sv | 23 ++
 rtl/uart_writer.sv | 92 +++++++++
 tb/tb_uart_writer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_writer_if.sv
// uart_writer_if: control, memory read port and UART TX byte signals of the readback writer
interface uart_writer_if;
    logic        start_i;
    logic [31:0] start_addr_i;
    logic [31:0] nwords_i;
    logic        busy_o;
    logic        done_o;
    logic        rd_req_o;
    logic [31:0] rd_addr_o;
    logic [31:0] rd_data_i;
    logic        rd_valid_i;
    logic [7:0]  uart_byte_o;
    logic        uart_valid_o;
    logic        uart_ready_i;
    modport slave (
        input  start_i, start_addr_i, nwords_i, rd_data_i, rd_valid_i, uart_ready_i,
        output busy_o, done_o, rd_req_o, rd_addr_o, uart_byte_o, uart_valid_o
    );
    modport master (
        output start_i, start_addr_i, nwords_i, rd_data_i, rd_valid_i, uart_ready_i,
        input  busy_o, done_o, rd_req_o, rd_addr_o, uart_byte_o, uart_valid_o
    );
endinterface

// File: rtl/uart_writer.sv
// uart_writer: streams a framed block of memory words out over the UART TX byte interface
module uart_writer #(
    parameter bit SEND_HEADER = 1'b1
) (
    input logic          clk_i,
    input logic          rst_n_i,
    uart_writer_if.slave bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HDR     = 3'd1;
    localparam logic [2:0] S_RD_REQ  = 3'd2;
    localparam logic [2:0] S_RD_WAIT = 3'd3;
    localparam logic [2:0] S_SEND    = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]  r_state;
    logic [31:0] r_buf;
    logic [1:0]  r_bidx;
    logic        r_hidx;
    logic [31:0] r_addr;
    logic [31:0] r_rem;
    logic [31:0] r_nwords;
    logic        w_fire;
    logic        w_rd_req;
    logic        w_valid;

    assign w_valid  = (r_state == S_SEND);
    assign w_fire   = w_valid && bus.uart_ready_i;
    assign w_rd_req = (r_state == S_RD_REQ);

    assign bus.busy_o       = (r_state != S_IDLE) && (r_state != S_DONE);
    assign bus.done_o       = (r_state == S_DONE);
    assign bus.rd_req_o     = w_rd_req;
    assign bus.rd_addr_o    = w_rd_req ? r_addr : 32'd0;
    assign bus.uart_valid_o = w_valid;
    assign bus.uart_byte_o  = w_valid ? r_buf[{r_bidx, 3'b000} +: 8] : 8'd0;

    // Sequencer: header words (start address is still in r_addr until the first read), then data words
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state  <= S_IDLE;
            r_buf    <= 32'd0;
            r_bidx   <= 2'd0;
            r_hidx   <= 1'b0;
            r_addr   <= 32'd0;
            r_rem    <= 32'd0;
            r_nwords <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start_i) begin
                        r_addr   <= bus.start_addr_i;
                        r_rem    <= bus.nwords_i;
                        r_nwords <= bus.nwords_i;
                        r_hidx   <= 1'b0;
                        r_state  <= SEND_HEADER ? S_HDR :
                                    (bus.nwords_i == 32'd0) ? S_DONE : S_RD_REQ;
                    end
                end
                S_HDR: begin
                    r_buf   <= r_hidx ? r_nwords : r_addr;
                    r_bidx  <= 2'd0;
                    r_state <= S_SEND;
                end
                S_RD_REQ: r_state <= S_RD_WAIT;
                S_RD_WAIT: begin
                    if (bus.rd_valid_i) begin
                        r_buf   <= bus.rd_data_i;
                        r_bidx  <= 2'd0;
                        r_addr  <= r_addr + 32'd1;
                        r_rem   <= r_rem - 32'd1;
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_fire) begin
                        r_bidx <= r_bidx + 2'd1;
                        if (r_bidx == 2'd3) begin
                            if (SEND_HEADER && !r_hidx) begin
                                r_hidx  <= 1'b1;
                                r_state <= S_HDR;
                            end else begin
                                r_state <= (r_rem != 32'd0) ? S_RD_REQ : S_DONE;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_writer.sv
// tb_uart_writer: directed vectors and corner sequences for the UART readback writer
module tb_uart_writer;
    typedef struct {
        logic [31:0]  addr;
        logic [31:0]  n;
        int           rnd;
        int           len;
        logic [127:0] exp;
        int           nrd;
        logic [31:0]  rd0;
        logic [31:0]  rdl;
    } vec_t;

    logic        clk;
    logic        rst_n;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          lat = 1;
    int          mode = 0;
    int          stab_bad = 0;
    int          last_hs = 0;
    logic [7:0]  got[$];
    logic [31:0] raddr[$];
    vec_t        vec[5];

    uart_writer_if bus();

    uart_writer #(.SEND_HEADER(1'b1)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [31:0] mem(logic [31:0] a);
        case (a)
            32'h0000_0010: return 32'hDEAD_BEEF;
            32'h0000_0011: return 32'h0102_0304;
            32'hFFFF_FFFF: return 32'h1122_3344;
            32'h0000_0000: return 32'h5566_7788;
            default:       return 32'hBAD0_BAD0;
        endcase
    endfunction

    // Memory model: answers each read request lat cycles later
    initial begin
        int          cnt;
        logic [31:0] pa;
        cnt = 0;
        pa = 32'd0;
        bus.rd_valid_i = 1'b0;
        bus.rd_data_i = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            bus.rd_valid_i = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.rd_valid_i = 1'b1;
                    bus.rd_data_i = mem(pa);
                end
            end
            if (bus.rd_req_o) begin
                cnt = lat;
                pa = bus.rd_addr_o;
                raddr.push_back(pa);
            end
        end
    end

    // TX sink: ready always high or pseudo-random
    initial begin
        bus.uart_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.uart_ready_i = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Byte monitor: records handshakes and flags a byte that changes or drops while stalled
    initial begin
        logic       pv, pr;
        logic [7:0] pb;
        pv = 1'b0;
        pr = 1'b0;
        pb = 8'd0;
        forever begin
            @(negedge clk);
            if (rst_n && pv && !pr && (!bus.uart_valid_o || bus.uart_byte_o !== pb))
                stab_bad++;
            if (bus.uart_valid_o && bus.uart_ready_i) begin
                got.push_back(bus.uart_byte_o);
                last_hs = cyc + 1;
            end
            pv = bus.uart_valid_o;
            pr = bus.uart_ready_i;
            pb = bus.uart_byte_o;
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_xfer(logic [31:0] a, logic [31:0] n);
        @(posedge clk);
        #1;
        bus.start_i = 1'b1;
        bus.start_addr_i = a;
        bus.nwords_i = n;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
    endtask

    task automatic wait_done(output int dc);
        dc = -1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (bus.done_o) begin
                dc = cyc;
                break;
            end
        end
        if (dc < 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_bytes(string tag, int b0, logic [127:0] exp, int len);
        chk({tag, "_count"}, 32'(got.size() - b0), 32'(len));
        for (int i = 0; i < len; i++)
            chk($sformatf("%s_byte%0d", tag, i),
                (b0 + i < got.size()) ? 32'(got[b0 + i]) : 32'hFFFF_FFFF, 32'(exp[8*i +: 8]));
    endtask

    initial begin
        int dc, b0, r0, ok;
        vec[0] = '{32'h10, 32'd2, 0, 16, {32'h0102_0304, 32'hDEAD_BEEF, 32'h2, 32'h10}, 2, 32'h10, 32'h11};
        vec[1] = '{32'h10, 32'd2, 1, 16, {32'h0102_0304, 32'hDEAD_BEEF, 32'h2, 32'h10}, 2, 32'h10, 32'h11};
        vec[2] = '{32'h20, 32'd0, 0, 8, {64'd0, 32'h0, 32'h20}, 0, 32'h0, 32'h0};
        vec[3] = '{32'hFFFF_FFFF, 32'd2, 0, 16, {32'h5566_7788, 32'h1122_3344, 32'h2, 32'hFFFF_FFFF}, 2, 32'hFFFF_FFFF, 32'h0};
        vec[4] = '{32'h10, 32'd1, 1, 12, {32'h0, 32'hDEAD_BEEF, 32'h1, 32'h10}, 1, 32'h10, 32'h10};
        rst_n = 1'b0;
        bus.start_i = 1'b0;
        bus.start_addr_i = 32'd0;
        bus.nwords_i = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_done", 32'(bus.done_o), 32'd0);
        chk("rst_rd_req", 32'(bus.rd_req_o), 32'd0);
        chk("rst_rd_addr", bus.rd_addr_o, 32'd0);
        chk("rst_valid", 32'(bus.uart_valid_o), 32'd0);
        chk("rst_byte", 32'(bus.uart_byte_o), 32'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 5; k++) begin
            mode = vec[k].rnd;
            lat = 1;
            b0 = got.size();
            r0 = raddr.size();
            start_xfer(vec[k].addr, vec[k].n);
            chk($sformatf("v%0d_busy_t1", k), 32'(bus.busy_o), 32'd1);
            chk($sformatf("v%0d_valid_t1", k), 32'(bus.uart_valid_o), 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid_t2", k), 32'(bus.uart_valid_o), 32'd1);
            chk($sformatf("v%0d_byte_t2", k), 32'(bus.uart_byte_o), 32'(vec[k].exp[7:0]));
            wait_done(dc);
            chk($sformatf("v%0d_done_after_last", k), 32'(dc), 32'(last_hs));
            chk($sformatf("v%0d_busy_end", k), 32'(bus.busy_o), 32'd0);
            chk($sformatf("v%0d_valid_end", k), 32'(bus.uart_valid_o), 32'd0);
            check_bytes($sformatf("v%0d", k), b0, vec[k].exp, vec[k].len);
            chk($sformatf("v%0d_nrd", k), 32'(raddr.size() - r0), 32'(vec[k].nrd));
            if (vec[k].nrd > 0 && raddr.size() >= r0 + vec[k].nrd) begin
                chk($sformatf("v%0d_rd_first", k), raddr[r0], vec[k].rd0);
                chk($sformatf("v%0d_rd_last", k), raddr[r0 + vec[k].nrd - 1], vec[k].rdl);
            end
            chk($sformatf("v%0d_stable", k), 32'(stab_bad), 32'd0);
        end

        mode = 0;
        b0 = got.size();
        r0 = raddr.size();
        start_xfer(32'h10, 32'd2);
        repeat (5) @(posedge clk);
        start_xfer(32'h99, 32'd5);
        wait_done(dc);
        check_bytes("restart_busy", b0, vec[0].exp, 16);
        chk("restart_busy_nrd", 32'(raddr.size() - r0), 32'd2);
        b0 = got.size();
        start_xfer(32'h20, 32'd0);
        chk("restart_done_cleared", 32'(bus.done_o), 32'd0);
        chk("restart_done_busy", 32'(bus.busy_o), 32'd1);
        wait_done(dc);
        check_bytes("restart_done", b0, vec[2].exp, 8);

        lat = 5;
        b0 = got.size();
        r0 = raddr.size();
        start_xfer(32'h10, 32'd2);
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (raddr.size() >= r0 + 2) begin
                ok = 1;
                break;
            end
        end
        chk("rst_mid_read_reached", 32'(ok), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_mid_done", 32'(bus.done_o), 32'd0);
        chk("rst_mid_rd_req", 32'(bus.rd_req_o), 32'd0);
        chk("rst_mid_rd_addr", bus.rd_addr_o, 32'd0);
        chk("rst_mid_valid", 32'(bus.uart_valid_o), 32'd0);
        chk("rst_mid_byte", 32'(bus.uart_byte_o), 32'd0);
        chk("rst_mid_sent", 32'(got.size() - b0), 32'd12);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("late_valid_busy", 32'(bus.busy_o), 32'd0);
        chk("late_valid_done", 32'(bus.done_o), 32'd0);
        chk("late_valid_uart", 32'(bus.uart_valid_o), 32'd0);
        chk("late_valid_rd_req", 32'(bus.rd_req_o), 32'd0);
        lat = 1;
        b0 = got.size();
        r0 = raddr.size();
        start_xfer(32'h10, 32'd2);
        wait_done(dc);
        check_bytes("post_rst", b0, vec[0].exp, 16);
        chk("post_rst_nrd", 32'(raddr.size() - r0), 32'd2);
        chk("stable_final", 32'(stab_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
